fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  RV32 instruction fetch stage, directly upstream of the decode/immediate-extension stage.
//  Owns the PC and issues sequential word fetches to instruction memory over a valid/ready request channel.
//  Returns data to a small in-order instruction buffer.
//  Presents inst, pc and a pre-decoded 2-bit immediate-format select (id_imm_mux) to decode with a valid/ready handshake.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC of the first fetch after reset
//  BUF_DEPTH  2              instruction buffer entries (power of 2, >=2); also max in-flight requests
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous active-low reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word-aligned fetch address (bits[1:0]=0)
//  imem_rsp_valid  in   1   response valid; in order; >=1 cycle after acceptance; no back-pressure
//  imem_rsp_data   in   32  fetched instruction word
//  redirect_valid  in   1   taken branch/jump/trap: restart fetch
//  redirect_pc     in   32  new PC; bits[1:0] ignored (forced 0)
//  id_valid        out  1   buffer head valid toward decode
//  id_ready        in   1   decode accepts head
//  id_inst         out  32  head instruction; 32'h0000_0013 (NOP) when id_valid=0
//  id_pc           out  32  PC of head instruction; 0 when id_valid=0
//  id_imm_mux      out  2   imm format: 00 I, 01 S, 10 B, 11 J
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, imem_req_valid=0, buffer empty, id_valid=0.
//   Also in-flight=0, drop=0, id_inst=NOP, id_pc=0, id_imm_mux=00.
//  Request issue:
//   - imem_req_valid=1 when inflight + buf_count < BUF_DEPTH and redirect_valid=0.
//   - imem_req_addr = pc. On acceptance (valid&&ready): pc += 4 (mod 2^32, wraps 0xFFFF_FFFC->0), inflight++.
//   - Request holds valid/addr stable until accepted unless a redirect occurs.
//  Response:
//   - On imem_rsp_valid, inflight-- the same cycle.
//   - If drop>0: discard data, drop--.
//   - Else write {data, pc_of_req, imm_mux} at tail. A per-request PC FIFO of BUF_DEPTH entries tracks pc_of_req.
//   - Data written on cycle N is visible at id_* on cycle N+1 (registered; no rsp->id comb path).
//  imm_mux decode on write, from inst[6:0]:
//   - 0100011 -> 01 (S); 1100011 -> 10 (B); 1101111 -> 11 (J).
//   - All other opcodes (incl. 0000011, 0010011, 1100111) -> 00.
//  Decode handshake:
//   - id_valid = buffer non-empty. Pop on id_valid&&id_ready.
//   - id_* stable while id_valid&&!id_ready.
//   - Push and pop in the same cycle are both performed; count unchanged.
//  Redirect (redirect_valid=1 at edge):
//   - pc <= {redirect_pc[31:2],2'b00}. Buffer flushed (id_valid=0 next cycle, pop that cycle ignored).
//   - drop <= inflight_next: includes a request accepted and a response arriving in the same cycle.
//   - imem_req_valid=0 during the redirect cycle; fetch from the new pc starts next cycle.
//   - Back-to-back redirects: last one wins; drop accumulates correctly.
//  Throughput: with imem_req_ready=1, 1-cycle memory and id_ready=1, one instruction per cycle is sustained.
//  Spurious imem_rsp_valid with inflight==0 is ignored; inflight never underflows or exceeds BUF_DEPTH.
// TESTING
//  1. Reset release, ready=1, 1-cycle mem -> addrs 0x0,0x4,0x8..., first id_valid 2 cycles after rst_n rises.
//     id_pc/id_inst match memory.
//  2. id_ready=0 -> exactly 2 requests accepted, then imem_req_valid=0.
//     id_* holds pc 0x0 until id_ready=1, then streaming resumes with no loss or duplication.
//  3. Redirect to 0x103 with 2 requests in flight -> next addr 0x100; both old responses dropped.
//     The next id_pc is 0x100.
//  4. Opcodes 0x23,0x63,0x6F,0x13,0x67 fetched -> id_imm_mux 01,10,11,00,00 respectively.
//  5. redirect_pc=0xFFFF_FFF8 -> addrs 0xFFFF_FFF8,0xFFFF_FFFC,0x0000_0000 (wrap).
//  6. Assert rst_n=0 mid-stream with full buffer -> id_valid and imem_req_valid drop immediately (async).
//     Restart at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 fetch stage issuing sequential imem requests into an in-order buffer with imm-format predecode
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [1:0]  id_imm_mux
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, count_q, count_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d, rq_head_q, rq_head_d, rq_tail_q, rq_tail_d;
    logic [31:0]   buf_inst_q [BUF_DEPTH];
    logic [31:0]   buf_pc_q [BUF_DEPTH];
    logic [1:0]    buf_imm_q [BUF_DEPTH];
    logic [31:0]   rq_pc_q [BUF_DEPTH];
    logic [CW:0]   occupancy;
    logic          accept, rsp_ok, push, pop, unused_pc_bits;
    logic [1:0]    imm_sel;
    logic [6:0]    opcode;

    always_comb begin
        id_valid = count_q != '0;
        pop = id_valid && id_ready;
        // a pop this cycle frees a slot, which keeps single-cycle memory streaming at full rate
        occupancy = {1'b0, inflight_q} + {1'b0, count_q} - (CW+1)'(pop);
        imem_req_valid = rst_n && !redirect_valid && occupancy < DEPTH_W;
        imem_req_addr = pc_q;
        accept = imem_req_valid && imem_req_ready;
        rsp_ok = imem_rsp_valid && inflight_q != '0;
        push = rsp_ok && drop_q == '0 && !redirect_valid;
        opcode = imem_rsp_data[6:0];
        imm_sel = opcode == 7'b0100011 ? 2'b01 :
                  opcode == 7'b1100011 ? 2'b10 :
                  opcode == 7'b1101111 ? 2'b11 : 2'b00;
        inflight_d = inflight_q + CW'(accept) - CW'(rsp_ok);
        pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : accept ? pc_q + 32'd4 : pc_q;
        // everything still outstanding after this edge belongs to the old path
        drop_d = redirect_valid ? inflight_d : (rsp_ok && drop_q != '0) ? drop_q - CW'(1) : drop_q;
        count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        head_d = redirect_valid ? '0 : head_q + AW'(pop);
        tail_d = redirect_valid ? '0 : tail_q + AW'(push);
        rq_head_d = rq_head_q + AW'(rsp_ok);
        rq_tail_d = rq_tail_q + AW'(accept);
        id_inst = id_valid ? buf_inst_q[head_q] : 32'h0000_0013;
        id_pc = id_valid ? buf_pc_q[head_q] : '0;
        id_imm_mux = id_valid ? buf_imm_q[head_q] : 2'b00;
        unused_pc_bits = ^redirect_pc[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            rq_head_q  <= '0;
            rq_tail_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            rq_head_q  <= rq_head_d;
            rq_tail_q  <= rq_tail_d;
        end
    end

    // request PCs stay queued across redirects so dropped responses still retire their entry
    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst_q[tail_q] <= imem_rsp_data;
            buf_pc_q[tail_q]   <= rq_pc_q[rq_head_q];
            buf_imm_q[tail_q]  <= imm_sel;
        end
        if (accept)
            rq_pc_q[rq_tail_q] <= pc_q;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a 1/2-cycle memory model and in-order stream checking
module tb_fetch_stage;
    logic        clk, rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        redirect_valid, id_valid, id_ready;
    logic [31:0] redirect_pc, id_inst, id_pc;
    logic [1:0]  id_imm_mux;

    int          checks, errors, acc_cnt;
    logic        p1v, p2v, lat2, acc;
    logic [31:0] p1a, p2a, acc_addr, exp_pc, exp_addr;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .id_imm_mux(id_imm_mux)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h200: mem_word = {a[24:0], 7'h23};
            32'h204: mem_word = {a[24:0], 7'h63};
            32'h208: mem_word = {a[24:0], 7'h6F};
            32'h20C: mem_word = {a[24:0], 7'h13};
            32'h210: mem_word = {a[24:0], 7'h67};
            default: mem_word = {a[24:0], 7'h13};
        endcase
    endfunction

    function automatic logic [1:0] imm_of(input logic [31:0] a);
        case (a)
            32'h200: imm_of = 2'b01;
            32'h204: imm_of = 2'b10;
            32'h208: imm_of = 2'b11;
            default: imm_of = 2'b00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        acc = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        if (acc) begin
            chk("req_addr", acc_addr, exp_addr);
            exp_addr += 32'd4;
            acc_cnt++;
        end
        if (id_valid && id_ready) begin
            chk("id_pc", id_pc, exp_pc);
            chk("id_inst", id_inst, mem_word(exp_pc));
            chk("id_imm_mux", 32'(id_imm_mux), 32'(imm_of(exp_pc)));
            exp_pc += 32'd4;
        end
        @(posedge clk);
        #1;
        p2v = p1v; p2a = p1a;
        p1v = acc; p1a = acc_addr;
        imem_rsp_valid = lat2 ? p2v : p1v;
        imem_rsp_data = mem_word(lat2 ? p2a : p1a);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        p1v = 1'b0; p2v = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_id_inst", id_inst, 32'h0000_0013);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_imm", 32'(id_imm_mux), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_pc = 32'd0; exp_addr = 32'd0; acc_cnt = 0;
        #1;
        chk("rel_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rel_req_addr", imem_req_addr, 32'd0);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc = target;
        #1;
        chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        chk("redir_flush", 32'(id_valid), 32'd0);
        redirect_valid = 1'b0;
        exp_pc = {target[31:2], 2'b00};
        exp_addr = {target[31:2], 2'b00};
        acc_cnt = 0;
    endtask

    task automatic wait_head(input string tag, input logic [31:0] pc);
        for (int i = 0; i < 12 && !id_valid; i++) tick();
        chk({tag, "_valid"}, 32'(id_valid), 32'd1);
        chk({tag, "_pc"}, id_pc, pc);
    endtask

    initial begin
        checks = 0; errors = 0; acc_cnt = 0;
        rst_n = 1'b1; lat2 = 1'b0; acc = 1'b0;
        p1v = 1'b0; p2v = 1'b0; p1a = '0; p2a = '0; acc_addr = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        exp_pc = '0; exp_addr = '0;
        #2;
        // reset release, 1-cycle memory: first id_valid two edges later
        do_reset();
        tick();
        chk("first_valid_early", 32'(id_valid), 32'd0);
        tick();
        chk("first_valid", 32'(id_valid), 32'd1);
        chk("first_pc", id_pc, 32'd0);
        chk("first_inst", id_inst, mem_word(32'd0));
        repeat (6) tick();
        // decode stall from reset: exactly two fetches, head held at 0x0
        id_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        chk("stall_accepts", 32'(acc_cnt), 32'd2);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_valid", 32'(id_valid), 32'd1);
        chk("stall_pc", id_pc, 32'd0);
        chk("stall_inst", id_inst, mem_word(32'd0));
        id_ready = 1'b1;
        repeat (8) tick();
        // switch to 2-cycle memory, redirect with two requests outstanding
        imem_req_ready = 1'b0;
        repeat (2) tick();
        lat2 = 1'b1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (p1v && p2v) break;
        end
        chk("two_inflight", 32'({p1v, p2v}), 32'd3);
        redirect(32'h0000_0103);
        wait_head("redir103", 32'h100);
        repeat (4) tick();
        // immediate-format predecode
        redirect(32'h0000_0200);
        repeat (16) tick();
        chk("imm_region_done", 32'(exp_pc >= 32'h214), 32'd1);
        // PC wrap at the top of the address space
        redirect(32'hFFFF_FFF8);
        repeat (10) tick();
        chk("wrap_accepts", 32'(acc_cnt >= 3), 32'd1);
        // back-to-back redirects: last one wins
        redirect(32'h0000_0300);
        redirect(32'h0000_0400);
        wait_head("b2b", 32'h400);
        repeat (4) tick();
        // async reset with a full buffer, then full-rate restart
        id_ready = 1'b0;
        repeat (6) tick();
        chk("full_valid", 32'(id_valid), 32'd1);
        #2;
        lat2 = 1'b0;
        id_ready = 1'b1;
        do_reset();
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("throughput", 32'(id_valid), 32'd1);
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
